// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential requests, credit-limited prefetch FIFO, IF/ID register.
// Define FETCH_PERF_CNT_EN to add the accepted-request and dropped-response counters.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            stallD,
    input  logic            flushD,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_drop_cnt,
`endif
    output logic            validD,
    output logic [XLEN-1:0] instrD,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pc4D
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [XLEN-1:0] pc_f_q, pc_f_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [CW-1:0]   credits;

    // Tag FIFO: PCs of live (not-to-be-dropped) outstanding requests, in issue order.
    logic [XLEN-1:0] tag_mem_q [DEPTH];
    logic [XLEN-1:0] tag_mem_d [DEPTH];
    logic [PW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    logic [XLEN-1:0] fifo_instr_q [DEPTH];
    logic [XLEN-1:0] fifo_instr_d [DEPTH];
    logic [XLEN-1:0] fifo_pc_q [DEPTH];
    logic [XLEN-1:0] fifo_pc_d [DEPTH];
    logic [PW-1:0]   fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;

    logic            vld_id_q, vld_id_d;
    logic [XLEN-1:0] instr_id_q, instr_id_d;
    logic [XLEN-1:0] pc_id_q, pc_id_d;
    logic [XLEN-1:0] pc4_id_q, pc4_id_d;

    logic req_fire;
    logic rsp_keep;
    logic rsp_drop;
    logic fifo_pop;

    always_comb begin
        credits        = CW'(DEPTH) - (outst_q + occ_q);
        imem_req_valid = (credits != '0) && !redirect_i;
        imem_req_addr  = pc_f_q;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_keep       = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_i;
        rsp_drop       = imem_rsp_valid && !rsp_keep;
        fifo_pop       = !stallD && !flushD && (occ_q != '0) && !redirect_i;
    end

    always_comb begin
        pc_f_d       = pc_f_q;
        outst_d      = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_cnt_d   = drop_cnt_q;
        tag_mem_d    = tag_mem_q;
        tag_wr_d     = tag_wr_q;
        tag_rd_d     = tag_rd_q;
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_wr_d    = fifo_wr_q;
        fifo_rd_d    = fifo_rd_q;
        occ_d        = occ_q + CW'(rsp_keep) - CW'(fifo_pop);

        if (redirect_i) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_f_d     = redirect_pc_i;
            drop_cnt_d = outst_q - CW'(imem_rsp_valid);
            tag_wr_d   = '0;
            tag_rd_d   = '0;
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            occ_d      = '0;
        end else begin
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            if (req_fire) begin
                pc_f_d              = pc_f_q + XLEN'(4);
                tag_mem_d[tag_wr_q] = pc_f_q;
                tag_wr_d            = tag_wr_q + 1'b1;
            end
            if (rsp_keep) begin
                fifo_instr_d[fifo_wr_q] = imem_rsp_data;
                fifo_pc_d[fifo_wr_q]    = tag_mem_q[tag_rd_q];
                fifo_wr_d               = fifo_wr_q + 1'b1;
                tag_rd_d                = tag_rd_q + 1'b1;
            end
            if (fifo_pop) begin
                fifo_rd_d = fifo_rd_q + 1'b1;
            end
        end
    end

    always_comb begin
        vld_id_d   = 1'b0;
        instr_id_d = '0;
        pc_id_d    = '0;
        pc4_id_d   = '0;
        if (stallD) begin
            vld_id_d   = vld_id_q;
            instr_id_d = instr_id_q;
            pc_id_d    = pc_id_q;
            pc4_id_d   = pc4_id_q;
        end else if (fifo_pop) begin
            vld_id_d   = 1'b1;
            instr_id_d = fifo_instr_q[fifo_rd_q];
            pc_id_d    = fifo_pc_q[fifo_rd_q];
            pc4_id_d   = fifo_pc_q[fifo_rd_q] + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f_q     <= RESET_PC;
            outst_q    <= '0;
            drop_cnt_q <= '0;
            occ_q      <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            vld_id_q   <= 1'b0;
            instr_id_q <= '0;
            pc_id_q    <= '0;
            pc4_id_q   <= '0;
        end else begin
            pc_f_q     <= pc_f_d;
            outst_q    <= outst_d;
            drop_cnt_q <= drop_cnt_d;
            occ_q      <= occ_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            vld_id_q   <= vld_id_d;
            instr_id_q <= instr_id_d;
            pc_id_q    <= pc_id_d;
            pc4_id_q   <= pc4_id_d;
        end
    end

    // Storage arrays need no reset; pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        tag_mem_q    <= tag_mem_d;
        fifo_instr_q <= fifo_instr_d;
        fifo_pc_q    <= fifo_pc_d;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_drop_q, perf_drop_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + 32'(req_fire);
        perf_drop_d  = perf_drop_q + 32'(rsp_drop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_drop_q  <= perf_drop_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_drop_cnt  = perf_drop_q;
`endif

    assign validD = vld_id_q;
    assign instrD = instr_id_q;
    assign pcD    = pc_id_q;
    assign pc4D   = pc4_id_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order variable-latency memory plus a queue-based reference model.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        stallD = 1'b0;
    logic        flushD = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        validD;
    logic [31:0] instrD, pcD, pc4D;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_drop_cnt;
`endif

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .stallD(stallD), .flushD(flushD),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt),
`endif
        .validD(validD), .instrD(instrD), .pcD(pcD), .pc4D(pc4D)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int t; } mem_t;
    typedef struct { logic [31:0] pc; int ep; } req_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

    mem_t mem_q[$];   // what the memory owes, driven by actual DUT handshakes
    req_t mq[$];      // model: outstanding requests tagged with the path epoch
    ent_t fq[$];      // model: prefetch buffer

    int cyc, last_rdy, lat_lo = 1, lat_hi = 1;
    int n_chk = 0, n_fail = 0;
    logic [31:0] m_pc;
    int          m_ep;
    logic        e_vld;
    logic [31:0] e_instr, e_pc, e_pc4;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Starts and ends at a negedge; applies one cycle of stimulus.
    task automatic step(input bit red, input logic [31:0] rpc, input bit st, input bit fl,
                        input bit rdy);
        int   credits;
        bit   exp_rv, pop_ok;
        ent_t head;
        req_t r;
        redirect_i = red; redirect_pc_i = rpc; stallD = st; flushD = fl; imem_req_ready = rdy;
        if (mem_q.size() > 0 && mem_q[0].t <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        credits = DEPTH - (mq.size() + fq.size());
        exp_rv  = (credits > 0) && !red;
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (exp_rv) chk("req_addr", imem_req_addr, m_pc);

        if (imem_rsp_valid) void'(mem_q.pop_front());
        if (imem_req_valid && rdy) begin
            last_rdy = imax(cyc + $urandom_range(lat_hi, lat_lo), last_rdy + 1);
            mem_q.push_back('{addr: imem_req_addr, t: last_rdy});
        end

        pop_ok = !st && !fl && (fq.size() > 0) && !red;
        if (st) begin
        end else if (pop_ok) begin
            head = fq.pop_front();
            e_vld = 1'b1; e_instr = head.instr; e_pc = head.pc; e_pc4 = head.pc + 32'd4;
        end else begin
            e_vld = 1'b0; e_instr = '0; e_pc = '0; e_pc4 = '0;
        end
        if (imem_rsp_valid && mq.size() > 0) begin
            r = mq.pop_front();
            if (r.ep == m_ep && !red) fq.push_back('{instr: instr_of(r.pc), pc: r.pc});
        end
        if (red) begin
            fq.delete();
            m_ep++;
            m_pc = rpc;
        end else if (exp_rv && rdy) begin
            mq.push_back('{pc: m_pc, ep: m_ep});
            m_pc = m_pc + 32'd4;
        end

        @(posedge clk);
        cyc++;
        #1;
        chk("validD", {31'b0, validD}, {31'b0, e_vld});
        chk("instrD", instrD, e_instr);
        chk("pcD", pcD, e_pc);
        chk("pc4D", pc4D, e_pc4);
        @(negedge clk);
    endtask

    // Asserts reset asynchronously mid-phase; memory and model are reset with it.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        redirect_i = 1'b0; stallD = 1'b0; flushD = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        chk("rst_validD", {31'b0, validD}, 32'd0);
        chk("rst_instrD", instrD, 32'd0);
        chk("rst_pcD", pcD, 32'd0);
        chk("rst_pc4D", pc4D, 32'd0);
        chk("rst_addr", imem_req_addr, 32'd0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
        mem_q.delete(); mq.delete(); fq.delete();
        cyc = 0; last_rdy = 0; m_pc = '0; m_ep = 0;
        e_vld = 1'b0; e_instr = '0; e_pc = '0; e_pc4 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_random(input int n, input int p_red, input int p_st, input int p_fl,
                              input int p_rdy);
        for (int i = 0; i < n; i++) begin
            step(($urandom % 100) < p_red, $urandom & 32'hFFFF_FFFC,
                 ($urandom % 100) < p_st, ($urandom % 100) < p_fl, ($urandom % 100) < p_rdy);
        end
    endtask

    task automatic wait_first_valid(input string tag, input logic [31:0] exp_pc);
        int  n;
        bit  seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 30) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b1);
            n++;
            if (validD === 1'b1) seen = 1'b1;
        end
        chk({tag, "_seen"}, {31'b0, seen}, 32'd1);
        chk({tag, "_pc"}, pcD, exp_pc);
    endtask

    initial begin
        int first;
        do_reset();

        // Back-to-back fetch with single-cycle memory: first instruction after three edges.
        lat_lo = 1; lat_hi = 1;
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b1);
            if (first == 0 && validD === 1'b1) first = i;
        end
        chk("first_valid_cycle", first, 32'd3);

        // Memory not ready for ten cycles, then released.
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        lat_lo = 1; lat_hi = 4;
        run_random(40, 0, 10, 0, 100);

        // Redirect with several responses in flight at three-cycle latency.
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h100, 1'b0, 1'b1, 1'b1);
        wait_first_valid("redirect_100", 32'h100);

        // Decode stall while the buffer fills, then release.
        lat_lo = 1; lat_hi = 2;
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Flush with stall is held off; flush alone inserts a bubble.
        step(1'b0, '0, 1'b1, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Redirect to the top of the address space: fetch wraps to zero.
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1);
        wait_first_valid("redirect_wrap", 32'hFFFF_FFFC);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("wrap_next_pcD", pcD, 32'h0);

        lat_lo = 1; lat_hi = 5;
        run_random(1500, 6, 25, 12, 75);

        // Reset in the middle of traffic.
        do_reset();
        lat_lo = 1; lat_hi = 3;
        run_random(800, 8, 20, 10, 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
